// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage RISC-V core.
// Owns the PC, talks to instruction memory over request/grant plus
// response-valid, and loads the IF/ID pipeline register.
// Optional feature: define FETCH_PERF_CNT_EN to add the FetchCount/KillCount
// performance counter outputs.
module fetch_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemRValid,
    input  logic [XLEN-1:0] ImemRData,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
`ifdef FETCH_PERF_CNT_EN
    output logic            FetchBusy,
    output logic [31:0]     FetchCount,
    output logic [31:0]     KillCount
`else
    output logic            FetchBusy
`endif
);

    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [XLEN-1:0] r_pcF;
    logic            r_kill;
    logic [XLEN-1:0] r_holdInstr;
    logic [XLEN-1:0] r_instrD;
    logic [XLEN-1:0] r_pcD;
    logic [XLEN-1:0] r_pcPlus4D;
    logic            r_validD;

    logic            w_imemReq;
    logic            w_respInWait;
    logic            w_discard;
    logic            w_deliver;
    logic            w_capture;
    logic [XLEN-1:0] w_word;
    logic [XLEN-1:0] w_pcPlus4;
    logic [XLEN-1:0] w_redirectPc;

    // FSM state register; reset puts the fetcher back in REQ immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: a stalled or killed response, or a redirect, decides where a response goes
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_REQ: begin
                if (w_imemReq && ImemGnt) begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ImemRValid) begin
                    if (r_kill || PCSrcE || !StallD) begin
                        w_nextState = ST_REQ;
                    end else begin
                        w_nextState = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (PCSrcE || !StallD) begin
                    w_nextState = ST_REQ;
                end
            end
            default: w_nextState = ST_REQ;
        endcase
    end

    // FSM outputs: a request is only offered from REQ and never during reset
    always_comb begin
        w_imemReq = (r_state == ST_REQ) && !StallF && !reset;
        FetchBusy = (r_state == ST_WAIT);
    end

    // Response classification: discard, deliver straight through, or park in the hold buffer
    always_comb begin
        w_respInWait = ImemRValid && (r_state == ST_WAIT);
        w_discard    = w_respInWait && (r_kill || PCSrcE);
        w_deliver    = !PCSrcE && !StallD &&
                       ((w_respInWait && !r_kill) || (r_state == ST_HOLD));
        w_capture    = w_respInWait && !r_kill && !PCSrcE && StallD;
        w_word       = (r_state == ST_HOLD) ? r_holdInstr : ImemRData;
        w_pcPlus4    = r_pcF + XLEN'(4);
        w_redirectPc = PCTargetE & ~XLEN'(3);
    end

    // PC and kill flag: a redirect wins over everything and marks any in-flight request as stale
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcF  <= XLEN'(RESET_PC);
            r_kill <= 1'b0;
        end else if (PCSrcE) begin
            r_pcF  <= w_redirectPc;
            r_kill <= ((r_state == ST_REQ) && w_imemReq && ImemGnt) ||
                      ((r_state == ST_WAIT) && !ImemRValid);
        end else begin
            if (w_deliver) begin
                r_pcF <= w_pcPlus4;
            end
            if (w_discard) begin
                r_kill <= 1'b0;
            end
        end
    end

    // Hold buffer keeps a response that arrived while decode was stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_holdInstr <= '0;
        end else if (w_capture) begin
            r_holdInstr <= ImemRData;
        end
    end

    // IF/ID register: flush beats stall, stall holds, otherwise deliver or insert a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instrD   <= NOP_INSTR;
            r_pcD      <= '0;
            r_pcPlus4D <= '0;
            r_validD   <= 1'b0;
        end else if (FlushD) begin
            r_instrD <= NOP_INSTR;
            r_validD <= 1'b0;
        end else if (StallD) begin
            r_instrD <= r_instrD;
        end else if (w_deliver) begin
            r_instrD   <= w_word;
            r_pcD      <= r_pcF;
            r_pcPlus4D <= w_pcPlus4;
            r_validD   <= 1'b1;
        end else begin
            r_instrD <= NOP_INSTR;
            r_validD <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: instructions handed to decode and responses thrown away
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FetchCount <= '0;
            KillCount  <= '0;
        end else begin
            if (w_deliver) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (w_discard) begin
                KillCount <= KillCount + 32'd1;
            end
        end
    end
`endif

    assign ImemReq  = w_imemReq;
    assign ImemAddr = r_pcF;
    assign InstrD   = r_instrD;
    assign PCD      = r_pcD;
    assign PCPlus4D = r_pcPlus4D;
    assign ValidD   = r_validD;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, table-driven bench for fetch_stage.
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt, ImemRValid;
    logic [31:0] ImemRData;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchBusy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount, KillCount;
`endif

    int checkCount;
    int errorCount;

    typedef struct {
        logic        sF, sD, fD, pcs;
        logic [31:0] tgt;
        logic        gnt, rv;
        logic [31:0] rd;
        logic        eReq;
        logic [31:0] eAddr, eInstr, ePcd, ePc4;
        logic        eValid, eBusy;
    } vec_t;

    vec_t tbl[5];

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .reset(reset),
        .StallF(StallF),
        .StallD(StallD),
        .FlushD(FlushD),
        .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE),
        .ImemReq(ImemReq),
        .ImemAddr(ImemAddr),
        .ImemGnt(ImemGnt),
        .ImemRValid(ImemRValid),
        .ImemRData(ImemRData),
        .InstrD(InstrD),
        .PCD(PCD),
        .PCPlus4D(PCPlus4D),
        .ValidD(ValidD),
`ifdef FETCH_PERF_CNT_EN
        .FetchBusy(FetchBusy),
        .FetchCount(FetchCount),
        .KillCount(KillCount)
`else
        .FetchBusy(FetchBusy)
`endif
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic sF, input logic sD, input logic fD,
                                 input logic pcs, input logic [31:0] tgt,
                                 input logic gnt, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        StallF     = sF;
        StallD     = sD;
        FlushD     = fD;
        PCSrcE     = pcs;
        PCTargetE  = tgt;
        ImemGnt    = gnt;
        ImemRValid = rv;
        ImemRData  = rd;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic eReq, input logic [31:0] eAddr,
                            input logic [31:0] eInstr, input logic [31:0] ePcd,
                            input logic [31:0] ePc4, input logic eValid, input logic eBusy);
        checkOutput({tag, ".ImemReq"}, {31'd0, ImemReq}, {31'd0, eReq});
        if (eReq) checkOutput({tag, ".ImemAddr"}, ImemAddr, eAddr);
        checkOutput({tag, ".InstrD"}, InstrD, eInstr);
        checkOutput({tag, ".PCD"}, PCD, ePcd);
        checkOutput({tag, ".PCPlus4D"}, PCPlus4D, ePc4);
        checkOutput({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, eValid});
        checkOutput({tag, ".FetchBusy"}, {31'd0, FetchBusy}, {31'd0, eBusy});
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;

        // Back-to-back fetch: grant in REQ, response the following cycle
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,
                   1'b1, 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0050_0093,
                   1'b0, 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,
                   1'b1, 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00A0_0113,
                   1'b0, 32'h4, 32'h13, 32'h0, 32'h4, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
                   1'b1, 32'h8, 32'h00A0_0113, 32'h4, 32'h8, 1'b1, 1'b0};

        reset = 1'b1;
        StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
        ImemGnt = 0; ImemRValid = 0; ImemRData = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkAll("reset", 1'b0, 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("reset.ImemAddr", ImemAddr, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(tbl[i].sF, tbl[i].sD, tbl[i].fD, tbl[i].pcs, tbl[i].tgt,
                          tbl[i].gnt, tbl[i].rv, tbl[i].rd);
            checkAll($sformatf("table%0d", i), tbl[i].eReq, tbl[i].eAddr, tbl[i].eInstr,
                     tbl[i].ePcd, tbl[i].ePc4, tbl[i].eValid, tbl[i].eBusy);
        end

        // Response lands while decode is stalled for three cycles
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        checkAll("hold0", 1, 32'h8, 32'h13, 32'h4, 32'h8, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 32'h1111_1111);
        checkAll("hold1", 0, 32'h8, 32'h13, 32'h4, 32'h8, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
        checkAll("hold2", 0, 32'h8, 32'h13, 32'h4, 32'h8, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkAll("hold3", 0, 32'h8, 32'h13, 32'h4, 32'h8, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkAll("hold4", 0, 32'h8, 32'h13, 32'h4, 32'h8, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkAll("hold5", 1, 32'hC, 32'h1111_1111, 32'h8, 32'hC, 1, 0);

        // Redirect while waiting; the late response must be dropped
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        checkAll("redir0", 1, 32'hC, 32'h13, 32'h8, 32'hC, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h0000_0103, 0, 0, 0);
        checkAll("redir1", 0, 32'hC, 32'h13, 32'h8, 32'hC, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkAll("redir2", 0, 32'h100, 32'h13, 32'h8, 32'hC, 0, 1);
        checkOutput("redir2.ImemAddr", ImemAddr, 32'h100);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        checkAll("redir3", 0, 32'h100, 32'h13, 32'h8, 32'hC, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkAll("redir4", 1, 32'h100, 32'h13, 32'h8, 32'hC, 0, 0);

        // Redirect, grant and flush in the same REQ cycle
        applyStimulus(0, 0, 1, 1, 32'h0000_0200, 1, 0, 0);
        checkAll("rgnt0", 1, 32'h100, 32'h13, 32'h8, 32'hC, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hCAFE_BABE);
        checkAll("rgnt1", 0, 32'h200, 32'h13, 32'h8, 32'hC, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        checkAll("rgnt2", 1, 32'h200, 32'h13, 32'h8, 32'hC, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0000_0033);
        checkAll("rgnt3", 0, 32'h200, 32'h13, 32'h8, 32'hC, 0, 1);
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        checkAll("rgnt4", 1, 32'h204, 32'h33, 32'h200, 32'h204, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkAll("flushOverStall", 1, 32'h204, 32'h13, 32'h200, 32'h204, 0, 0);

        // StallF suppresses requests even when memory would grant
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
        checkAll("stallF0", 0, 32'h204, 32'h13, 32'h200, 32'h204, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkAll("stallF1", 0, 32'h204, 32'h13, 32'h200, 32'h204, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        checkAll("stallF2", 1, 32'h204, 32'h13, 32'h200, 32'h204, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkAll("stallF3", 0, 32'h204, 32'h13, 32'h200, 32'h204, 0, 1);

`ifdef FETCH_PERF_CNT_EN
        checkOutput("FetchCount", FetchCount, 32'd4);
        checkOutput("KillCount", KillCount, 32'd2);
`endif

        // Reset in WAIT, then a stale response before any new grant
        reset = 1'b1;
        ImemGnt = 0; ImemRValid = 0;
        #1;
        checkAll("midReset", 0, 32'h0, 32'h13, 32'h0, 32'h0, 0, 0);
        checkOutput("midReset.ImemAddr", ImemAddr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0000_0BAD);
        checkAll("stale0", 1, 32'h0, 32'h13, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        checkAll("stale1", 1, 32'h0, 32'h13, 32'h0, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0050_0093);
        checkAll("stale2", 0, 32'h0, 32'h13, 32'h0, 32'h0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkAll("stale3", 1, 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
